afu_tx_wr_buffer: RTL
=====================

# afu_tx_wr_buffer

Channel-1 transmit buffer between `afu_top` write/interrupt request outputs and the CCI channel-1 TX port. It absorbs `spl_tx_wr_almostfull` backpressure in a 16-entry FIFO and caps in-flight writes by counting write responses from both RX channels. It presents a registered almost-full back to the AFU and reports idle and protocol errors.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth = 2^DEPTH_LOG2 entries.
- `ALMFULL_THRESH`, 12: `afu_wr_almostfull` asserts when occupancy >= this value.
- `MAX_OUTSTANDING`, 64: maximum unacknowledged writes issued to CCI.

Ports:
- `clk` in 1: CCI interface clock, the 32ui LP-domain clock.
- `reset` in 1: asynchronous, active-high reset.
- `afu_wr_valid` in 1: AFU write request.
- `afu_intr_valid` in 1: AFU interrupt request.
- `afu_wr_hdr` in 99: request header.
- `afu_wr_data` in 512: write data, ignored for interrupts.
- `afu_wr_almostfull` out 1: registered backpressure to the AFU.
- `spl_tx_wr_almostfull` in 1: CCI channel-1 almost full.
- `spl_rx_wr_valid0` in 1: write response on RX channel 0.
- `spl_rx_wr_valid1` in 1: write response on RX channel 1.
- `tx_wr_valid` out 1: CCI channel-1 write valid, registered.
- `tx_intr_valid` out 1: CCI channel-1 interrupt valid, registered.
- `tx_wr_hdr` out 99: header for the current tx valid.
- `tx_data` out 512: data for the current tx valid.
- `wr_outstanding` out clog2(MAX_OUTSTANDING+1): writes issued but not yet acknowledged.
- `idle` out 1: FIFO empty, no writes outstanding, no tx valid this cycle.
- `err` out 1: sticky protocol-error flag.

## Operation
- FIFO entry layout: {is_intr, hdr[98:0], data[511:0]}.
- **Push** occurs on `afu_wr_valid | afu_intr_valid`.
  - If both valids are high: push a write entry, drop the interrupt, set `err`.
  - Push while the FIFO is full: entry dropped, `err` set, pointers unchanged.
- **Pop** condition: FIFO non-empty AND !`spl_tx_wr_almostfull` AND (head.is_intr OR `wr_outstanding` < MAX_OUTSTANDING).
  - At most one pop per cycle.
  - Interrupts bypass the outstanding cap but keep FIFO order; nothing is reordered.
- **Pop output, next cycle:** `tx_wr_valid` = !is_intr, `tx_intr_valid` = is_intr, and `tx_wr_hdr`/`tx_data` take the head entry. With no pop, both valids are 0 and hdr/data hold their last value.
- **Outstanding counter:**
  - +1 on a write pop (not on an interrupt pop).
  - -1 for each of `spl_rx_wr_valid0` and `spl_rx_wr_valid1`.
  - Net update applied in one cycle (e.g. pop + two responses = -1).
  - Decrement below 0 saturates at 0 and sets `err`.
- **Occupancy:** push and pop in the same cycle leave occupancy unchanged. Pointers wrap modulo 2^DEPTH_LOG2. Occupancy counter is DEPTH_LOG2+1 bits wide.
- `afu_wr_almostfull` is registered from the next-state occupancy >= ALMFULL_THRESH. The AFU may issue up to DEPTH-ALMFULL_THRESH (4) further requests after it asserts.
- `err` clears only on reset.

## Timing
- Reset values: all valids 0, `tx_wr_hdr`/`tx_data` 0, `wr_outstanding` 0, `afu_wr_almostfull` 0, `err` 0, `idle` 1, FIFO empty.
- Latency: push in cycle N; head visible in N+1; earliest `tx_*_valid` in cycle N+2.
- Throughput: one request per cycle when unthrottled.
- `spl_tx_wr_almostfull` is sampled combinationally in the pop decision. A pop issued in the same cycle it rises is permitted, since CCI almost-full guarantees slack.
- `idle` is combinational from registered state.
- Reset mid-operation: FIFO contents, pending valids, and the outstanding count are discarded immediately. Responses arriving after reset saturate at 0 and set `err`.

## Test plan
- Single write, CCI not full: push at cycle 0 -> `tx_wr_valid`=1 at cycle 2 with matching hdr/data; `wr_outstanding`=1; one `spl_rx_wr_valid1` -> 0; `idle`=1.
- Hold `spl_tx_wr_almostfull`=1 and push 16 writes -> `afu_wr_almostfull`=1 the cycle after the 12th push; a 17th push sets `err`. Release almost-full -> 16 `tx_wr_valid` pulses in order on consecutive cycles.
- MAX_OUTSTANDING=64 with no responses: 70 writes -> exactly 64 issued, then stall. Two simultaneous responses on valid0 and valid1 -> 2 more issued.
- Interrupt behind the write cap: 64 writes outstanding, head is an interrupt -> `tx_intr_valid`=1 and `wr_outstanding` stays 64.
- Simultaneous `afu_wr_valid`=1 and `afu_intr_valid`=1 -> one write entry emitted, `err`=1. A response with count 0 -> count stays 0, `err`=1.
- Assert `reset` with 5 entries queued and 3 outstanding -> all outputs return to reset values asynchronously; no tx valid after deassertion.

Source files
------------

// File: rtl/afu_tx_wr_buffer.sv
// CCI channel-1 transmit buffer: queues AFU write/interrupt requests behind
// spl_tx_wr_almostfull and caps unacknowledged writes issued to CCI.
module afu_tx_wr_buffer #(
    parameter int DEPTH_LOG2      = 4,
    parameter int ALMFULL_THRESH  = 12,
    parameter int MAX_OUTSTANDING = 64,
    localparam int OutW           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            afu_wr_valid,
    input  logic            afu_intr_valid,
    input  logic [98:0]     afu_wr_hdr,
    input  logic [511:0]    afu_wr_data,
    output logic            afu_wr_almostfull,
    input  logic            spl_tx_wr_almostfull,
    input  logic            spl_rx_wr_valid0,
    input  logic            spl_rx_wr_valid1,
    output logic            tx_wr_valid,
    output logic            tx_intr_valid,
    output logic [98:0]     tx_wr_hdr,
    output logic [511:0]    tx_data,
    output logic [OutW-1:0] wr_outstanding,
    output logic            idle,
    output logic            err
);

    localparam int Depth  = 1 << DEPTH_LOG2;
    localparam int EntryW = 1 + 99 + 512;
    localparam int CntW   = DEPTH_LOG2 + 1;

    logic [EntryW-1:0]     fifoMem [Depth];
    logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
    logic [CntW-1:0]       count, countNext;
    logic [EntryW-1:0]     pushEntry, headEntry;
    logic                  pushReq, pushOk, popOk, writePop, headIsIntr;
    logic                  fifoEmpty, fifoFull, bothValid;
    logic [OutW:0]         outSum, rspTotal;
    logic                  outUnderflow;
    logic [OutW-1:0]       outNext;
    logic                  errEvent;

    assign headEntry  = fifoMem[rdPtr];
    assign headIsIntr = headEntry[EntryW-1];

    // NOTE: every signal gets a default before any branch so always_comb never infers a latch.
    always_comb begin
        pushReq   = afu_wr_valid | afu_intr_valid;
        bothValid = afu_wr_valid & afu_intr_valid;
        fifoEmpty = (count == '0);
        fifoFull  = (count == CntW'(Depth));
        pushOk    = pushReq & ~fifoFull;
        // A simultaneous write and interrupt is stored as the write only.
        pushEntry = {~afu_wr_valid, afu_wr_hdr, afu_wr_data};

        popOk     = ~fifoEmpty & ~spl_tx_wr_almostfull &
                    (headIsIntr | (wr_outstanding < OutW'(MAX_OUTSTANDING)));
        writePop  = popOk & ~headIsIntr;

        countNext = count;
        if (pushOk && !popOk)
            countNext = count + 1'b1;
        else if (!pushOk && popOk)
            countNext = count - 1'b1;

        outSum       = {1'b0, wr_outstanding} + (OutW + 1)'(writePop);
        rspTotal     = (OutW + 1)'(spl_rx_wr_valid0) + (OutW + 1)'(spl_rx_wr_valid1);
        outUnderflow = (outSum < rspTotal);
        outNext      = outUnderflow ? '0 : OutW'(outSum - rspTotal);

        errEvent  = bothValid | (pushReq & fifoFull) | outUnderflow;
    end

    // NOTE: payload storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (pushOk)
            fifoMem[wrPtr] <= pushEntry;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr             <= '0;
            rdPtr             <= '0;
            count             <= '0;
            wr_outstanding    <= '0;
            afu_wr_almostfull <= 1'b0;
            err               <= 1'b0;
            tx_wr_valid       <= 1'b0;
            tx_intr_valid     <= 1'b0;
            tx_wr_hdr         <= '0;
            tx_data           <= '0;
        end else begin
            if (pushOk)
                wrPtr <= wrPtr + 1'b1;
            if (popOk)
                rdPtr <= rdPtr + 1'b1;
            count             <= countNext;
            wr_outstanding    <= outNext;
            afu_wr_almostfull <= (countNext >= CntW'(ALMFULL_THRESH));
            if (errEvent)
                err <= 1'b1;
            tx_wr_valid   <= writePop;
            tx_intr_valid <= popOk & headIsIntr;
            // Header and data hold their last value between pops.
            if (popOk) begin
                tx_wr_hdr <= headEntry[EntryW-2 -: 99];
                tx_data   <= headEntry[511:0];
            end
        end
    end

    assign idle = fifoEmpty & (wr_outstanding == '0) & ~tx_wr_valid & ~tx_intr_valid;

endmodule
